// File: rtl/inst_encoder_loader.sv
// Packs field-level instruction requests into 16-bit words and streams them to imem.
// Latency: a field accepted in cycle t can be written at the earliest in cycle t+1.
// Backpressure: imem_ready low holds the FIFO head; in_ready drops when the FIFO is full.

// Show-ahead FIFO: head_dat is valid whenever !empty; the caller never pushes when full.
// Latency: a word pushed in cycle t is visible at the head in t+1.
// Backpressure: full is evaluated before any same-cycle pop, so there is no bypass.
module inst_encoder_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);
    assign head_dat = mem_q[rd_ptr_q];
endmodule

module inst_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [1:0]        in_rs,
    input  logic [1:0]        in_rt,
    input  logic [1:0]        in_rd,
    input  logic [7:0]        in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W:0]   acc_cnt_q, acc_cnt_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic        is_rfmt, is_illegal;
    logic [15:0] enc_word, head_dat;
    logic        accept, push, pop, fifo_full, fifo_empty;

    always_comb begin
        is_rfmt    = in_opcode inside {4'd2, 4'd4, 4'd5, 4'd7, 4'd13};
        is_illegal = (in_opcode[3:1] == 3'b111);
        if (is_rfmt) begin
            enc_word = {in_opcode, in_rs, in_rt, in_rd, in_imm[5:0]};
        end else begin
            enc_word = {in_opcode, in_rs, in_rt, in_imm};
        end
    end

    assign in_ready = (state_q == LOAD) && !fifo_full && (acc_cnt_q < num_q);
    assign accept   = in_valid && in_ready;
    // Illegal opcodes are consumed from the request stream but never reach memory.
    assign push     = accept && !is_illegal;
    assign pop      = imem_we && imem_ready;

    inst_encoder_fifo #(
        .W     (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (enc_word),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    num_d     = num_words;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                    err_d     = 1'b0;
                    state_d   = (num_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (push) begin
                    acc_cnt_d = acc_cnt_q + CNT_ONE;
                end
                if (accept && is_illegal) begin
                    err_d = 1'b1;
                end
                if (pop) begin
                    wr_cnt_d = wr_cnt_q + CNT_ONE;
                    if ((wr_cnt_q + CNT_ONE) == num_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign imem_we     = !fifo_empty;
    assign imem_addr   = base_q + wr_cnt_q[ADDR_W-1:0];
    assign imem_wdata  = fifo_empty ? 16'h0000 : head_dat;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_illegal = err_q;
endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader; expected words and addresses are hand-computed.
module tb_inst_encoder_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_words;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [1:0]  in_rs, in_rt, in_rd;
    logic [7:0]  in_imm;
    logic        imem_we;
    logic        imem_ready;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        busy, done, err_illegal;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0]  mon_addr[$];
    logic [15:0] mon_data[$];
    int          mon_cyc[$];
    logic [7:0]  exp_addr[$];
    logic [15:0] exp_data[$];

    inst_encoder_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_ready  (imem_ready),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after the rising edge, so the handshake seen here is the one the next edge commits.
    always @(negedge clk) begin
        if (imem_we && imem_ready) begin
            mon_addr.push_back(imem_addr);
            mon_data.push_back(imem_wdata);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic do_start(input logic [7:0] base, input logic [8:0] num);
        start     = 1'b1;
        base_addr = base;
        num_words = num;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input string tag, input logic [3:0] op, input logic [1:0] rs,
                        input logic [1:0] rt, input logic [1:0] rd, input logic [7:0] imm);
        bit ok;
        ok        = 1'b0;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check_vec({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check_vec({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic compare_writes(input string tag);
        check_vec({tag, "_nwrites"}, mon_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < mon_addr.size()) begin
                check_vec($sformatf("%s_addr%0d", tag, i), mon_addr[i], exp_addr[i]);
                check_vec($sformatf("%s_data%0d", tag, i), mon_data[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_words  = '0;
        in_valid   = 1'b1;
        in_opcode  = '0;
        in_rs      = '0;
        in_rt      = '0;
        in_rd      = '0;
        in_imm     = '0;
        imem_ready = 1'b1;

        // 1. reset and idle
        #2;
        check_vec("rst_imem_we", imem_we, 0);
        check_vec("rst_imem_addr", imem_addr, 0);
        check_vec("rst_imem_wdata", imem_wdata, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_done", done, 0);
        check_vec("rst_err", err_illegal, 0);
        check_vec("rst_in_ready", in_ready, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_vec("idle_in_ready", in_ready, 0);
        check_vec("idle_busy", busy, 0);
        in_valid = 1'b0;

        // 2. single R-format word
        clear_mon();
        do_start(8'h10, 9'd1);
        check_vec("r_busy", busy, 1);
        in_opcode = 4'd2; in_rs = 2'd1; in_rt = 2'd2; in_rd = 2'd3; in_imm = 8'h15;
        in_valid  = 1'b1;
        #1;
        check_vec("r_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_vec("r_we", imem_we, 1);
        check_vec("r_addr", imem_addr, 8'h10);
        check_vec("r_wdata", imem_wdata, 16'h26D5);
        check_vec("r_done_early", done, 0);
        tick();
        check_vec("r_done", done, 1);
        check_vec("r_busy_in_done", busy, 1);
        check_vec("r_we_after", imem_we, 0);
        tick();
        check_vec("r_done_pulse", done, 0);
        check_vec("r_busy_end", busy, 0);

        // 3. I-format stream, back to back
        clear_mon();
        do_start(8'h00, 9'd3);
        send("i0", 4'h0, 2'd3, 2'd0, 2'd2, 8'hA5);
        send("i1", 4'hC, 2'd0, 2'd0, 2'd1, 8'hFF);
        send("i2", 4'h1, 2'd1, 2'd1, 2'd3, 8'h00);
        wait_done("i");
        tick();
        exp_addr = '{8'h00, 8'h01, 8'h02};
        exp_data = '{16'h0CA5, 16'hC0FF, 16'h1500};
        compare_writes("i");
        if (mon_cyc.size() == 3) begin
            check_vec("i_b2b_1", mon_cyc[1] - mon_cyc[0], 1);
            check_vec("i_b2b_2", mon_cyc[2] - mon_cyc[1], 1);
        end

        // 4. backpressure
        clear_mon();
        imem_ready = 1'b0;
        do_start(8'h40, 9'd3);
        send("bp0", 4'd4, 2'd0, 2'd1, 2'd2, 8'h3F);
        send("bp1", 4'd8, 2'd2, 2'd3, 2'd0, 8'h5A);
        in_opcode = 4'd13; in_rs = 2'd3; in_rt = 2'd3; in_rd = 2'd1; in_imm = 8'hC7;
        in_valid  = 1'b1;
        #1;
        check_vec("bp_in_ready_full", in_ready, 0);
        check_vec("bp_we", imem_we, 1);
        check_vec("bp_addr", imem_addr, 8'h40);
        check_vec("bp_wdata", imem_wdata, 16'h41BF);
        tick();
        tick();
        #1;
        check_vec("bp_addr_hold", imem_addr, 8'h40);
        check_vec("bp_wdata_hold", imem_wdata, 16'h41BF);
        check_vec("bp_in_ready_hold", in_ready, 0);
        tick();
        imem_ready = 1'b1;
        send("bp2", 4'd13, 2'd3, 2'd3, 2'd1, 8'hC7);
        wait_done("bp");
        tick();
        exp_addr = '{8'h40, 8'h41, 8'h42};
        exp_data = '{16'h41BF, 16'h8B5A, 16'hDF47};
        compare_writes("bp");

        // 5a. illegal opcode and address wrap
        clear_mon();
        do_start(8'hFF, 9'd2);
        send("il0", 4'hE, 2'd1, 2'd1, 2'd1, 8'h11);
        check_vec("il_err", err_illegal, 1);
        send("il1", 4'd3, 2'd1, 2'd0, 2'd2, 8'h81);
        send("il2", 4'd7, 2'd2, 2'd1, 2'd0, 8'h2A);
        check_vec("il_in_ready_cap", in_ready, 0);
        wait_done("il");
        tick();
        check_vec("il_err_sticky", err_illegal, 1);
        exp_addr = '{8'hFF, 8'h00};
        exp_data = '{16'h3481, 16'h792A};
        compare_writes("il");

        // 5b. zero-length load
        clear_mon();
        do_start(8'h20, 9'd0);
        check_vec("z_done", done, 1);
        check_vec("z_err_cleared", err_illegal, 0);
        check_vec("z_we", imem_we, 0);
        tick();
        check_vec("z_busy", busy, 0);
        check_vec("z_nwrites", mon_addr.size(), 0);

        // 6. reset mid-load, start while busy ignored
        clear_mon();
        imem_ready = 1'b0;
        do_start(8'h30, 9'd4);
        send("rm0", 4'd1, 2'd0, 2'd0, 2'd0, 8'h01);
        send("rm1", 4'd1, 2'd0, 2'd0, 2'd0, 8'h02);
        do_start(8'h99, 9'd1);
        check_vec("rm_addr_kept", imem_addr, 8'h30);
        check_vec("rm_busy", busy, 1);
        check_vec("rm_we_pre", imem_we, 1);
        rst_n = 1'b0;
        #1;
        check_vec("rm_we", imem_we, 0);
        check_vec("rm_busy_rst", busy, 0);
        check_vec("rm_in_ready", in_ready, 0);
        tick();
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        tick();
        clear_mon();
        do_start(8'h50, 9'd1);
        send("rs0", 4'd9, 2'd0, 2'd2, 2'd1, 8'h33);
        wait_done("rs");
        tick();
        exp_addr = '{8'h50};
        exp_data = '{16'h9233};
        compare_writes("rs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
